// File: rtl/hack_mem_pkg.sv
// Shared constants, region encoding and address decode for the Hack data-memory subsystem.
package hack_mem_pkg;

  localparam int unsigned AddrW    = 15;
  localparam int unsigned DataW    = 16;
  localparam int unsigned ScrAddrW = 13;

  localparam logic [15:0] RAM_BASE       = 16'h0000;
  localparam logic [15:0] SCR_BASE       = 16'h4000;
  localparam logic [15:0] KBD_ADDR       = 16'h6000;
  localparam logic [15:0] KBD_EMPTY_CODE = 16'h0000;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_SCR,
    REGION_KBD,
    REGION_NONE
  } region_e;

  // Decode on addressM[14:13]; only the single word 0x6000 is mapped in the top quarter.
  function automatic region_e decode_region(input logic [AddrW-1:0] addr);
    region_e region;
    if (addr[14] == RAM_BASE[14]) begin
      region = REGION_RAM;
    end else if (addr[13] == SCR_BASE[13]) begin
      region = REGION_SCR;
    end else if (addr == KBD_ADDR[AddrW-1:0]) begin
      region = REGION_KBD;
    end else begin
      region = REGION_NONE;
    end
    return region;
  endfunction

endpackage

// File: rtl/hack_data_memory_if.sv
// CPU data bus, keyboard push port and display scan port of the Hack data memory.
// Define HACK_MEM_BUS_ERR_EN to add the sticky bus_err flag.
interface hack_data_memory_if;
  import hack_mem_pkg::*;

  logic [AddrW-1:0]    addressM;
  logic [DataW-1:0]    outM;
  logic                writeM;
  logic [DataW-1:0]    inM;
  logic [DataW-1:0]    kbd_data;
  logic                kbd_valid;
  logic                kbd_ready;
  logic [ScrAddrW-1:0] scr_addr;
  logic [DataW-1:0]    scr_data;
`ifdef HACK_MEM_BUS_ERR_EN
  logic                bus_err;

  modport master (
    output addressM, outM, writeM, kbd_data, kbd_valid, scr_addr,
    input  inM, kbd_ready, scr_data, bus_err
  );

  modport slave (
    input  addressM, outM, writeM, kbd_data, kbd_valid, scr_addr,
    output inM, kbd_ready, scr_data, bus_err
  );
`else
  modport master (
    output addressM, outM, writeM, kbd_data, kbd_valid, scr_addr,
    input  inM, kbd_ready, scr_data
  );

  modport slave (
    input  addressM, outM, writeM, kbd_data, kbd_valid, scr_addr,
    output inM, kbd_ready, scr_data
  );
`endif

endinterface

// File: rtl/hack_kbd_fifo.sv
// Keyboard code FIFO: push when not full, pop when not empty, head shown combinationally.
module hack_kbd_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(Depth);

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign full_o  = (count_q == FullCount);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/hack_data_memory.sv
// Hack data memory: RAM, screen buffer with registered scan port, and keyboard FIFO at 0x6000.
// Define HACK_MEM_BUS_ERR_EN to add a sticky bus_err flag set by unmapped writes.
module hack_data_memory
  import hack_mem_pkg::*;
#(
  parameter int unsigned RAM_WORDS      = 16384,
  parameter int unsigned SCR_WORDS      = 8192,
  parameter int unsigned KBD_FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               reset,
  hack_data_memory_if.slave bus
);

  localparam int unsigned RamAw = $clog2(RAM_WORDS);
  localparam int unsigned ScrAw = $clog2(SCR_WORDS);

  logic [DataW-1:0] ram_q [RAM_WORDS];
  logic [DataW-1:0] scr_q [SCR_WORDS];
  logic [DataW-1:0] scr_data_q;

  region_e          region;
  logic [RamAw-1:0] ram_idx;
  logic [ScrAw-1:0] scr_idx;
  logic [ScrAw-1:0] scan_idx;
  logic             kbd_pop;
  logic             kbd_full, kbd_empty;
  logic [DataW-1:0] kbd_head;
  logic [DataW-1:0] rdata;

  assign region   = decode_region(bus.addressM);
  assign ram_idx  = bus.addressM[RamAw-1:0];
  assign scr_idx  = bus.addressM[ScrAw-1:0];
  assign scan_idx = bus.scr_addr[ScrAw-1:0];
  assign kbd_pop  = bus.writeM && (region == REGION_KBD);

  hack_kbd_fifo #(
    .Depth (KBD_FIFO_DEPTH),
    .Width (DataW)
  ) u_kbd_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (bus.kbd_valid),
    .data_i  (bus.kbd_data),
    .pop_i   (kbd_pop),
    .full_o  (kbd_full),
    .empty_o (kbd_empty),
    .head_o  (kbd_head)
  );

  assign bus.kbd_ready = !kbd_full;

  // Zero-latency read so an A-instruction followed by an M access works in one cycle.
  always_comb begin
    rdata = '0;
    unique case (region)
      REGION_RAM:  rdata = ram_q[ram_idx];
      REGION_SCR:  rdata = scr_q[scr_idx];
      REGION_KBD:  rdata = kbd_empty ? KBD_EMPTY_CODE : kbd_head;
      default:     rdata = '0;
    endcase
  end

  assign bus.inM = rdata;

  always_ff @(posedge clk) begin
    if (bus.writeM && (region == REGION_RAM)) ram_q[ram_idx] <= bus.outM;
    if (bus.writeM && (region == REGION_SCR)) scr_q[scr_idx] <= bus.outM;
  end

  // Scan read samples the pre-write word when the CPU writes the same location.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scr_data_q <= '0;
    end else begin
      scr_data_q <= scr_q[scan_idx];
    end
  end

  assign bus.scr_data = scr_data_q;

`ifdef HACK_MEM_BUS_ERR_EN
  logic bus_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_err_q <= 1'b0;
    end else if (bus.writeM && (region == REGION_NONE)) begin
      bus_err_q <= 1'b1;
    end
  end

  assign bus.bus_err = bus_err_q;
`endif

endmodule

// File: tb/tb_hack_data_memory.sv
// Directed vector bench for hack_data_memory: decode, RAM/screen access, keyboard FIFO, reset.
module tb_hack_data_memory;
  import hack_mem_pkg::*;

  typedef struct {
    logic [14:0] a;
    logic [15:0] d;
    logic        w;
    logic [15:0] kd;
    logic        kv;
    logic [12:0] sa;
    logic [15:0] e_inm;
    logic        e_rdy;
    logic [15:0] e_scr;
    logic [2:0]  chk;   // {inM, kbd_ready, scr_data}
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t vq[$];

  hack_data_memory_if bus ();

  hack_data_memory #(
    .RAM_WORDS      (16384),
    .SCR_WORDS      (8192),
    .KBD_FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [14:0] a, input logic [15:0] d, input logic w,
                              input logic [15:0] kd, input logic kv, input logic [12:0] sa,
                              input logic [15:0] e_inm, input logic e_rdy,
                              input logic [15:0] e_scr, input logic [2:0] chk);
    vec_t v;
    v = '{a: a, d: d, w: w, kd: kd, kv: kv, sa: sa,
          e_inm: e_inm, e_rdy: e_rdy, e_scr: e_scr, chk: chk};
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.addressM  = v.a;
    bus.outM      = v.d;
    bus.writeM    = v.w;
    bus.kbd_data  = v.kd;
    bus.kbd_valid = v.kv;
    bus.scr_addr  = v.sa;
  endtask

  task automatic step(input vec_t v, input int idx);
    @(negedge clk);
    drive(v);
    #1;
    if (v.chk[2]) check($sformatf("v%0d.inM", idx), bus.inM, v.e_inm);
    if (v.chk[1]) check($sformatf("v%0d.kbd_ready", idx), {15'b0, bus.kbd_ready},
                        {15'b0, v.e_rdy});
    @(posedge clk);
    #1;
    if (v.chk[0]) check($sformatf("v%0d.scr_data", idx), bus.scr_data, v.e_scr);
  endtask

  task automatic idle(input logic [14:0] a, input logic [12:0] sa);
    drive(mk(a, 16'h0, 1'b0, 16'h0, 1'b0, sa, 16'h0, 1'b0, 16'h0, 3'b000));
  endtask

  initial begin
    // RAM/screen setup, unmapped write, screen read-before-write
    vq.push_back(mk(15'h0010, 16'h1234, 1, 16'h0, 0, 13'h0000, 16'h0000, 1, 16'h0000, 3'b010));
    vq.push_back(mk(15'h3000, 16'h1111, 1, 16'h0, 0, 13'h0000, 16'h0000, 1, 16'h0000, 3'b010));
    vq.push_back(mk(15'h5000, 16'h2222, 1, 16'h0, 0, 13'h0000, 16'h0000, 1, 16'h0000, 3'b010));
    vq.push_back(mk(15'h0010, 16'h0000, 0, 16'h0, 0, 13'h0000, 16'h1234, 1, 16'h0000, 3'b110));
    vq.push_back(mk(15'h7000, 16'hBEEF, 1, 16'h0, 0, 13'h0000, 16'h0000, 1, 16'h0000, 3'b110));
    vq.push_back(mk(15'h3000, 16'h0000, 0, 16'h0, 0, 13'h1000, 16'h1111, 1, 16'h2222, 3'b111));
    vq.push_back(mk(15'h5000, 16'h0000, 0, 16'h0, 0, 13'h1000, 16'h2222, 1, 16'h2222, 3'b111));
    vq.push_back(mk(15'h6001, 16'hBEEF, 1, 16'h0, 0, 13'h0000, 16'h0000, 1, 16'h0000, 3'b110));
    vq.push_back(mk(15'h0010, 16'h0000, 0, 16'h0, 0, 13'h0000, 16'h1234, 1, 16'h0000, 3'b100));
    vq.push_back(mk(15'h4005, 16'hAAAA, 1, 16'h0, 0, 13'h0005, 16'h0000, 1, 16'h0000, 3'b010));
    vq.push_back(mk(15'h4005, 16'hFFFF, 1, 16'h0, 0, 13'h0005, 16'hAAAA, 1, 16'hAAAA, 3'b111));
    vq.push_back(mk(15'h4005, 16'h0000, 0, 16'h0, 0, 13'h0005, 16'hFFFF, 1, 16'hFFFF, 3'b111));
    // Fill to full, drop a push while full, pop through, pop on empty
    vq.push_back(mk(15'h6000, 16'h0, 0, 16'h0041, 1, 13'h5, 16'h0000, 1, 16'hFFFF, 3'b111));
    vq.push_back(mk(15'h6000, 16'h0, 0, 16'h0042, 1, 13'h5, 16'h0041, 1, 16'hFFFF, 3'b110));
    vq.push_back(mk(15'h6000, 16'h0, 0, 16'h0043, 1, 13'h5, 16'h0041, 1, 16'hFFFF, 3'b110));
    vq.push_back(mk(15'h6000, 16'h0, 0, 16'h0044, 1, 13'h5, 16'h0041, 1, 16'hFFFF, 3'b110));
    vq.push_back(mk(15'h6000, 16'h0, 0, 16'h0045, 1, 13'h5, 16'h0041, 0, 16'hFFFF, 3'b110));
    vq.push_back(mk(15'h6000, 16'h0, 1, 16'h0000, 0, 13'h5, 16'h0041, 0, 16'hFFFF, 3'b110));
    vq.push_back(mk(15'h6000, 16'h0, 1, 16'h0000, 0, 13'h5, 16'h0042, 1, 16'hFFFF, 3'b110));
    vq.push_back(mk(15'h6000, 16'h0, 1, 16'h0000, 0, 13'h5, 16'h0043, 1, 16'hFFFF, 3'b110));
    vq.push_back(mk(15'h6000, 16'h0, 1, 16'h0000, 0, 13'h5, 16'h0044, 1, 16'hFFFF, 3'b110));
    vq.push_back(mk(15'h6000, 16'h0, 1, 16'h0000, 0, 13'h5, 16'h0000, 1, 16'hFFFF, 3'b110));
    // Push+pop while empty, push+pop at two entries, wrap-around ordering
    vq.push_back(mk(15'h6000, 16'h0, 1, 16'h0080, 1, 13'h5, 16'h0000, 1, 16'hFFFF, 3'b110));
    vq.push_back(mk(15'h6000, 16'h0, 0, 16'h0030, 1, 13'h5, 16'h0080, 1, 16'hFFFF, 3'b110));
    vq.push_back(mk(15'h6000, 16'h0, 1, 16'h0031, 1, 13'h5, 16'h0080, 1, 16'hFFFF, 3'b110));
    vq.push_back(mk(15'h6000, 16'h0, 0, 16'h0032, 1, 13'h5, 16'h0030, 1, 16'hFFFF, 3'b110));
    vq.push_back(mk(15'h6000, 16'h0, 0, 16'h0033, 1, 13'h5, 16'h0030, 1, 16'hFFFF, 3'b110));
    vq.push_back(mk(15'h6000, 16'h0, 1, 16'h0000, 0, 13'h5, 16'h0030, 0, 16'hFFFF, 3'b110));
    vq.push_back(mk(15'h6000, 16'h0, 1, 16'h0000, 0, 13'h5, 16'h0031, 1, 16'hFFFF, 3'b110));
    vq.push_back(mk(15'h6000, 16'h0, 1, 16'h0000, 0, 13'h5, 16'h0032, 1, 16'hFFFF, 3'b110));
    vq.push_back(mk(15'h6000, 16'h0, 1, 16'h0000, 0, 13'h5, 16'h0033, 1, 16'hFFFF, 3'b110));
    vq.push_back(mk(15'h6000, 16'h0, 0, 16'h0000, 0, 13'h5, 16'h0000, 1, 16'hFFFF, 3'b111));

    reset = 1'b0;
    idle(15'h6000, 13'h0);
    #1;
    check("reset.scr_data", bus.scr_data, 16'h0000);
    check("reset.kbd_ready", {15'b0, bus.kbd_ready}, 16'h0001);
    check("reset.kbd_read", bus.inM, KBD_EMPTY_CODE);
`ifdef HACK_MEM_BUS_ERR_EN
    check("reset.bus_err", {15'b0, bus.bus_err}, 16'h0000);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vq.size(); i++) step(vq[i], i);

`ifdef HACK_MEM_BUS_ERR_EN
    check("bus_err.sticky", {15'b0, bus.bus_err}, 16'h0001);
`endif

    // Queue three codes, then reset asynchronously in mid-cycle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(mk(15'h6000, 16'h0, 0, 16'h0051 + 16'(i), 1, 13'h5, 16'h0, 0, 16'h0, 3'b000));
    end
    @(negedge clk);
    idle(15'h6000, 13'h5);
    #1;
    check("burst.head", bus.inM, 16'h0051);
    check("burst.kbd_ready", {15'b0, bus.kbd_ready}, 16'h0001);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midreset.kbd_ready", {15'b0, bus.kbd_ready}, 16'h0001);
    check("midreset.kbd_read", bus.inM, 16'h0000);
    check("midreset.scr_data", bus.scr_data, 16'h0000);
`ifdef HACK_MEM_BUS_ERR_EN
    check("midreset.bus_err", {15'b0, bus.bus_err}, 16'h0000);
`endif
    @(negedge clk);
    reset = 1'b1;
    idle(15'h0010, 13'h5);
    #1;
    check("postreset.ram", bus.inM, 16'h1234);
    bus.addressM = 15'h6000;
    #1;
    check("postreset.kbd_read", bus.inM, 16'h0000);
    @(posedge clk);
    #1;
    check("postreset.scr_data", bus.scr_data, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hack_data_memory.md
Name: hack_data_memory

Overview:
- Data-memory subsystem directly downstream of the CPU. It consumes addressM, outM and writeM, and returns inM.
- Implements the memory map:
  - RAM: 0x0000–0x3FFF
  - Screen buffer: 0x4000–0x5FFF
  - Keyboard register: 0x6000
- Adds a buffered keyboard input (valid/ready FIFO) and a registered second read port, so the display scanner can read screen words.

Parameters:
- RAM_WORDS, 16384, RAM depth in words (power of 2, ≤16384).
- SCR_WORDS, 8192, screen buffer depth in words.
- KBD_FIFO_DEPTH, 4, keyboard FIFO entries (power of 2, ≥2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- addressM  input  15  CPU data address.
- outM  input  16  CPU write data.
- writeM  input  1  CPU write strobe, sampled on the rising clk edge.
- inM  output  16  read data to the CPU, combinational from addressM.
- kbd_data  input  16  key code from the keyboard front-end.
- kbd_valid  input  1  kbd_data is valid.
- kbd_ready  output  1  FIFO can accept a code.
- scr_addr  input  13  screen word address from the display scanner.
- scr_data  output  16  screen word, registered.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low.
- Reset values:
  - FIFO empty; read/write pointers and count = 0.
  - kbd_ready = 1 in the first cycle after reset deasserts.
  - scr_data = 0.
  - RAM and screen contents are not cleared.
  - Reset asserted mid-operation discards any FIFO contents immediately.
- Address decode on addressM[14:13]:
  - 00, 01 → RAM.
  - 10 → screen, index addressM[12:0].
  - 11 with addressM[12:0]==0 → KBD.
  - Anything else → unmapped.
- CPU read path (zero latency):
  - inM is combinational from the current addressM, so an A-instruction followed by M-use works in the same cycle.
  - KBD reads return the FIFO head, or 0x0000 when empty.
  - Unmapped reads return 0x0000.
- CPU write path (rising edge, writeM=1):
  - RAM/screen: the word is written.
  - KBD: the write acts as a pop. It discards the head if non-empty; the data value is ignored. A pop on an empty FIFO has no effect.
  - Unmapped: the write is ignored.
- Write-then-read: a read of the same address in the next cycle returns the new value.
- Keyboard FIFO:
  - kbd_ready = !full (combinational from count).
  - Push occurs when kbd_valid && kbd_ready.
  - Push and pop in the same cycle:
    - Non-empty: both occur, count unchanged.
    - Empty: the push occurs, the pop is ignored.
    - Full: kbd_ready=0, so only the pop occurs.
  - Pointers wrap modulo KBD_FIFO_DEPTH.
  - A code of 0x0000 is pushed like any other code. Software cannot distinguish it from empty; this is the front-end's responsibility.
- Screen scan port:
  - scr_data <= screen[scr_addr], one-cycle latency, every cycle.
  - CPU write and scan read of the same word in the same cycle: scr_data returns the old word (read-before-write).

Optional Feature:
- Macro: HACK_MEM_BUS_ERR_EN.
- Defined:
  - Adds output bus_err (1 bit).
  - bus_err sets on any rising edge where addressM is unmapped and writeM=1, or where the address is unmapped and a read is in progress.
  - For verification, "read" means the A-register targets that address during any clocked cycle in which writeM=0. Only writes are counted for determinism.
  - Net rule: bus_err sets on an unmapped write. It is sticky and cleared only by reset (0 at reset).
- Undefined: no bus_err port and no extra logic. Unmapped writes are silently ignored.

Decomposition:
- Package hack_mem_pkg:
  - Constants: RAM_BASE=0x0000, SCR_BASE=0x4000, KBD_ADDR=0x6000.
  - Region-select encoding (REGION_RAM, REGION_SCR, REGION_KBD, REGION_NONE).
  - KBD_EMPTY_CODE=0x0000.
- Sub-module hack_kbd_fifo:
  - Parameterised depth; push/pop/full/empty/head.
  - Same clk and active-low asynchronous reset.
- Top-level contents: decode, RAM array, screen array and read muxing.

Test Plan:
- Release reset, then write 0x1234 to address 0x0010; next cycle set addressM=0x0010 → inM=0x1234. Set addressM=0x7000 with writeM=1 and outM=0xBEEF → no array changes. With the macro defined, bus_err=1.
- Write 0xFFFF to 0x4005 while scr_addr=5 in the same cycle → scr_data=old value next cycle, then 0xFFFF one cycle later.
- Push codes 0x0041, 0x0042, 0x0043, 0x0044 → kbd_ready=0 after the 4th. Read 0x6000 → 0x0041. Write 0x6000 → next read gives 0x0042, and kbd_ready=1.
- With the FIFO empty, read 0x6000 → 0x0000. A pop (write 0x6000) on empty leaves count=0. Push 0x0080 and pop in the same cycle while empty → head=0x0080.
- With the FIFO at 2 entries, push 0x0031 and pop in the same cycle → count stays 2, head advances, and the new code lands at the tail. Push past 4 pointer wraps and check order is preserved.
- Assert reset mid-burst with 3 codes queued → kbd_ready=1, KBD read=0x0000, scr_data=0. RAM word 0x0010 still reads 0x1234 after release.
